// File: rtl/svc_test_sched.sv
// ============================================================================
// svc_test_sched
//
// Hardware test-case scheduler. Runs NUM_TESTS directed test cases one at a
// time against a shared harness. For each case it optionally performs a setup
// handshake, issues a one-cycle start pulse, waits for done/pass under a
// watchdog, and tallies the result. A suite is launched by 'run' while idle.
//
// Optional feature macro: SVC_TEST_SCHED_ABORT_EN
//   defined   : the first failing or timed-out case ends the suite early and
//               test_idx keeps the index of that failing case
//   undefined : every case runs, failures are only tallied
//
// Ports:
//   clk           clock
//   rst_n         synchronous reset, active-low
//   run           start a suite (sampled only while idle)
//   setup_mask    bit i set: case i needs a setup handshake (latched at run)
//   setup_valid   setup request for test_idx
//   setup_ready   setup complete; handshake on setup_valid && setup_ready
//   test_idx      index of the current case
//   test_start    one-cycle pulse launching case test_idx
//   test_done     case finished (honoured only while waiting)
//   test_pass     case result, sampled together with test_done
//   busy          high while a suite is in progress, through suite_done
//   suite_done    one-cycle pulse after the last case is tallied
//   pass_cnt      cases passed in this suite
//   fail_cnt      cases failed in this suite, including timeouts
//   timeout_seen  sticky flag: some case of this suite timed out
// ============================================================================
module svc_test_sched #(
    parameter int NUM_TESTS = 8,
    parameter int TIMEOUT   = 1024,
    parameter int IDX_W     = $clog2(NUM_TESTS) + ((NUM_TESTS == 1) ? 1 : 0),
    parameter int CNT_W     = IDX_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [NUM_TESTS-1:0] setup_mask,
    output logic                 setup_valid,
    input  logic                 setup_ready,
    output logic [IDX_W-1:0]     test_idx,
    output logic                 test_start,
    input  logic                 test_done,
    input  logic                 test_pass,
    output logic                 busy,
    output logic                 suite_done,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 timeout_seen
);

    localparam int               TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TESTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_TESTS-1:0] mask_q;
    logic [TMR_W-1:0]     timer;
    logic [IDX_W-1:0]     idx_inc;
    logic                 last_case;

    assign idx_inc = test_idx + IDX_W'(1);

`ifdef SVC_TEST_SCHED_ABORT_EN
    // Remembers whether the case just finished failed, so NEXT can end the
    // suite early without waiting for the registered counters.
    logic case_failed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            case_failed <= 1'b0;
        end else if (state == S_START) begin
            case_failed <= 1'b0;
        end else if (state == S_WAIT) begin
            if ((test_done && !test_pass) || (!test_done && timer == TMR_LAST)) begin
                case_failed <= 1'b1;
            end
        end
    end

    assign last_case = (test_idx == IDX_LAST) || case_failed;
`else
    assign last_case = (test_idx == IDX_LAST);
`endif

    // Next-state and strobe outputs; all strobes derive from the current state.
    always_comb begin
        state_nxt   = state;
        setup_valid = 1'b0;
        test_start  = 1'b0;
        suite_done  = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nxt = setup_mask[0] ? S_SETUP : S_START;
                end
            end
            S_SETUP: begin
                setup_valid = 1'b1;
                if (setup_ready) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                test_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving in the expiry cycle takes priority over timeout.
                if (test_done || timer == TMR_LAST) begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_case) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = mask_q[idx_inc] ? S_SETUP : S_START;
                end
            end
            S_DONE: begin
                suite_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register plus the datapath: mask latch, case index, watchdog timer
    // and result tallies. Tallies hold after the suite until the next run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            mask_q       <= '0;
            test_idx     <= '0;
            timer        <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            timeout_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        mask_q       <= setup_mask;
                        test_idx     <= '0;
                        pass_cnt     <= '0;
                        fail_cnt     <= '0;
                        timeout_seen <= 1'b0;
                    end
                end
                S_START: begin
                    timer <= '0;
                end
                S_WAIT: begin
                    timer <= timer + TMR_W'(1);
                    if (test_done) begin
                        if (test_pass) begin
                            pass_cnt <= pass_cnt + CNT_W'(1);
                        end else begin
                            fail_cnt <= fail_cnt + CNT_W'(1);
                        end
                    end else if (timer == TMR_LAST) begin
                        fail_cnt     <= fail_cnt + CNT_W'(1);
                        timeout_seen <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (!last_case) begin
                        test_idx <= idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_svc_test_sched.sv
// ============================================================================
// tb_svc_test_sched
//
// Self-checking bench for svc_test_sched with NUM_TESTS=4, TIMEOUT=16.
// A table of directed suites and a batch of random suites are run through a
// cycle-level responder that plays the setup engine and the test harness.
// Expected tallies and busy duration come from hand-derived table entries or
// from a per-case arithmetic model of the suite. Honours
// SVC_TEST_SCHED_ABORT_EN the same way as the design.
// ============================================================================
module tb_svc_test_sched;

    localparam int NT = 4;
    localparam int TO = 16;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] setup_mask;
    logic       setup_valid;
    logic       setup_ready;
    logic [1:0] test_idx;
    logic       test_start;
    logic       test_done;
    logic       test_pass;
    logic       busy;
    logic       suite_done;
    logic [2:0] pass_cnt;
    logic [2:0] fail_cnt;
    logic       timeout_seen;

    int checks = 0;
    int errors = 0;

    svc_test_sched #(.NUM_TESTS(NT), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .setup_mask   (setup_mask),
        .setup_valid  (setup_valid),
        .setup_ready  (setup_ready),
        .test_idx     (test_idx),
        .test_start   (test_start),
        .test_done    (test_done),
        .test_pass    (test_pass),
        .busy         (busy),
        .suite_done   (suite_done),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .timeout_seen (timeout_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lat[i]: WAIT cycle (1-based) on which case i reports done; 0 or >TO = never
    typedef struct packed {
        logic [3:0]      mask;
        logic [3:0][4:0] lat;
        logic [3:0]      pass;
        logic [2:0]      delay;
        logic [2:0]      exp_pass;
        logic [2:0]      exp_fail;
        logic            exp_to;
        logic [1:0]      exp_idx;
        logic [7:0]      exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [3:0][4:0] mk_lat(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][4:0] l;
        l[0] = 5'(a0);
        l[1] = 5'(a1);
        l[2] = 5'(a2);
        l[3] = 5'(a3);
        return l;
    endfunction

    function automatic vec_t mk_vec(input logic [3:0] m, input logic [3:0][4:0] l, input logic [3:0] p,
                                    input int d, input int ep, input int ef, input int eto,
                                    input int eidx, input int ecyc);
        vec_t v;
        v.mask     = m;
        v.lat      = l;
        v.pass     = p;
        v.delay    = 3'(d);
        v.exp_pass = 3'(ep);
        v.exp_fail = 3'(ef);
        v.exp_to   = 1'(eto);
        v.exp_idx  = 2'(eidx);
        v.exp_cyc  = 8'(ecyc);
        return v;
    endfunction

    // Suite model: each executed case costs its setup cycles, one start cycle,
    // its WAIT cycles (done latency, capped at TO) and one step cycle; the suite
    // adds one final done cycle.
    function automatic vec_t with_model(input vec_t v);
        vec_t r;
        int   ep, ef, eto, eidx, ecyc, w, lat;
        bit   timed;
        r = v;
        ep = 0; ef = 0; eto = 0; eidx = 0; ecyc = 1;
        for (int i = 0; i < NT; i++) begin
            lat   = int'(v.lat[i]);
            timed = (lat == 0) || (lat > TO);
            w     = timed ? TO : lat;
            eidx  = i;
            ecyc += (v.mask[i] ? int'(v.delay) : 0) + 1 + w + 1;
            if (timed) begin
                ef++;
                eto = 1;
            end else if (v.pass[i]) begin
                ep++;
            end else begin
                ef++;
            end
`ifdef SVC_TEST_SCHED_ABORT_EN
            if (timed || !v.pass[i]) break;
`endif
        end
        r.exp_pass = 3'(ep);
        r.exp_fail = 3'(ef);
        r.exp_to   = 1'(eto);
        r.exp_idx  = 2'(eidx);
        r.exp_cyc  = 8'(ecyc);
        return r;
    endfunction

    // Runs one suite. Called at a negedge with the DUT idle. Inputs not part of
    // an active handshake are driven with random noise, including run.
    task automatic apply_stimulus(input vec_t v);
        int cyc, busy_cyc, sv_cnt, wcnt, exp_case;
        bit in_wait, setup_ok, done_seen;
        setup_mask  = v.mask;
        run         = 1'b1;
        setup_ready = 1'b0;
        test_done   = 1'b0;
        test_pass   = 1'b0;
        cyc = 0; busy_cyc = 0; sv_cnt = 0; wcnt = 0; exp_case = 0;
        in_wait = 1'b0; setup_ok = 1'b0; done_seen = 1'b0;
        while (!done_seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (setup_valid) begin
                check_output("setup_only_for_masked_case", int'(v.mask[test_idx]), 1);
            end
            if (test_start) begin
                check_output("start_idx", int'(test_idx), exp_case);
                if (exp_case < NT) begin
                    check_output("start_after_setup", int'(setup_ok || !v.mask[exp_case]), 1);
                end
                exp_case++;
                setup_ok = 1'b0;
                in_wait  = 1'b1;
                wcnt     = 0;
            end
            if (suite_done) begin
                done_seen = 1'b1;
                check_output("pass_cnt", int'(pass_cnt), int'(v.exp_pass));
                check_output("fail_cnt", int'(fail_cnt), int'(v.exp_fail));
                check_output("timeout_seen", int'(timeout_seen), int'(v.exp_to));
                check_output("final_idx", int'(test_idx), int'(v.exp_idx));
                check_output("busy_cycles", busy_cyc, int'(v.exp_cyc));
                check_output("cases_started", exp_case, int'(v.exp_idx) + 1);
            end
            if (done_seen) begin
                run = 1'b0; setup_ready = 1'b0; test_done = 1'b0; test_pass = 1'b0;
            end else begin
                run        = 1'($urandom_range(0, 1));
                setup_mask = 4'($urandom_range(0, 15));
                if (setup_valid) begin
                    sv_cnt++;
                    setup_ready = (sv_cnt >= int'(v.delay));
                    if (setup_ready) setup_ok = 1'b1;
                end else begin
                    sv_cnt      = 0;
                    setup_ready = 1'($urandom_range(0, 1));
                end
                if (in_wait && !test_start) begin
                    wcnt++;
                    test_done = (wcnt == int'(v.lat[exp_case-1]));
                    test_pass = v.pass[exp_case-1];
                    if (test_done || wcnt == TO) in_wait = 1'b0;
                end else begin
                    test_done = 1'($urandom_range(0, 1));
                    test_pass = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!done_seen) begin
            check_output("suite_done_within_bound", 0, 1);
        end
        @(negedge clk);
        check_output("busy_low_after_done", int'(busy), 0);
        check_output("single_done_pulse", int'(suite_done), 0);
        repeat (2) @(negedge clk);
        check_output("pass_cnt_hold", int'(pass_cnt), int'(v.exp_pass));
        check_output("fail_cnt_hold", int'(fail_cnt), int'(v.exp_fail));
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        bit   stray_done;

        // lat, pass bit i corresponds to case i
`ifdef SVC_TEST_SCHED_ABORT_EN
        vecs[0] = mk_vec(4'b0000, mk_lat(2, 2, 2, 2), 4'b1111, 1, 4, 0, 0, 3, 17);
        vecs[1] = mk_vec(4'b0101, mk_lat(1, 3, 2, 5), 4'b1111, 3, 4, 0, 0, 3, 26);
        vecs[2] = mk_vec(4'b0000, mk_lat(2, 0, 2, 2), 4'b1111, 1, 1, 1, 1, 1, 23);
        vecs[3] = mk_vec(4'b0000, mk_lat(2, 16, 2, 2), 4'b1111, 1, 4, 0, 0, 3, 31);
        vecs[4] = mk_vec(4'b0000, mk_lat(2, 2, 2, 2), 4'b1011, 1, 2, 1, 0, 2, 13);
        vecs[5] = mk_vec(4'b1010, mk_lat(1, 1, 1, 1), 4'b0000, 1, 0, 1, 0, 0, 4);
`else
        vecs[0] = mk_vec(4'b0000, mk_lat(2, 2, 2, 2), 4'b1111, 1, 4, 0, 0, 3, 17);
        vecs[1] = mk_vec(4'b0101, mk_lat(1, 3, 2, 5), 4'b1111, 3, 4, 0, 0, 3, 26);
        vecs[2] = mk_vec(4'b0000, mk_lat(2, 0, 2, 2), 4'b1111, 1, 3, 1, 1, 3, 31);
        vecs[3] = mk_vec(4'b0000, mk_lat(2, 16, 2, 2), 4'b1111, 1, 4, 0, 0, 3, 31);
        vecs[4] = mk_vec(4'b0000, mk_lat(2, 2, 2, 2), 4'b1011, 1, 3, 1, 0, 3, 17);
        vecs[5] = mk_vec(4'b1010, mk_lat(1, 1, 1, 1), 4'b0000, 1, 0, 4, 0, 3, 15);
`endif

        rst_n = 1'b0; run = 1'b0; setup_mask = '0; setup_ready = 1'b0;
        test_done = 1'b0; test_pass = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_test_start", int'(test_start), 0);
        check_output("reset_setup_valid", int'(setup_valid), 0);
        check_output("reset_suite_done", int'(suite_done), 0);
        check_output("reset_pass_cnt", int'(pass_cnt), 0);
        check_output("reset_fail_cnt", int'(fail_cnt), 0);
        check_output("reset_timeout_seen", int'(timeout_seen), 0);
        check_output("reset_test_idx", int'(test_idx), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed table");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i]);
        end

        $display("[TB] random suites");
        for (int n = 0; n < 25; n++) begin
            v.mask  = 4'($urandom_range(0, 15));
            v.lat   = mk_lat($urandom_range(0, 18), $urandom_range(0, 18),
                             $urandom_range(0, 18), $urandom_range(0, 18));
            for (int i = 0; i < NT; i++) v.pass[i] = ($urandom_range(0, 3) != 0);
            v.delay = 3'($urandom_range(1, 4));
            v = with_model(v);
            apply_stimulus(v);
        end

        // Reset while case 1 is waiting: suite aborts with no done pulse.
        $display("[TB] reset during wait");
        setup_mask = 4'b0000;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check_output("abort_seq_start0", int'(test_start), 1);
        @(negedge clk);
        test_done = 1'b1; test_pass = 1'b1;
        @(negedge clk);
        test_done = 1'b0;
        check_output("abort_seq_pass_cnt", int'(pass_cnt), 1);
        @(negedge clk);
        check_output("abort_seq_start1_idx", int'(test_idx), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_pass_cnt", int'(pass_cnt), 0);
        check_output("abort_test_idx", int'(test_idx), 0);
        stray_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (suite_done || busy) stray_done = 1'b1;
        end
        check_output("abort_no_suite_done", int'(stray_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
